// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_port_arbiter: round-robin arbiter/sequencer that shares one        |
// | fixed-latency memory port between instruction fetch and the MEM stage. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_addr,
  output logic        if_req_ready,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req_valid,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(MEM_LATENCY - 1);
  localparam logic       C_FETCH    = 1'b0;
  localparam logic       C_DATA     = 1'b1;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_last_grant;
  logic        r_owner_d;
  logic        r_we;
  logic        r_drop;
  logic        r_if_rsp;
  logic        r_d_rsp;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        w_idle;
  logic        w_d_acc;
  logic        w_if_acc;
  logic        w_done;
  logic        w_fetch_busy;

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign w_idle       = (r_state == S_IDLE) && !reset;
  assign d_req_ready  = w_idle && !(if_req_valid && (r_last_grant == C_DATA));
  assign if_req_ready = w_idle && !(d_req_valid && (r_last_grant == C_FETCH));
  assign w_d_acc      = d_req_valid && d_req_ready;
  assign w_if_acc     = if_req_valid && if_req_ready;
  assign w_done       = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_fetch_busy = (r_state != S_IDLE) && !r_owner_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_be    = 4'd0;
    unique case (r_state)
      S_IDLE: begin
        if (w_d_acc || w_if_acc) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_next    = S_WAIT;
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_be    = r_be;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 4'd0;
      r_last_grant <= C_FETCH;
      r_owner_d    <= 1'b0;
      r_we         <= 1'b0;
      r_drop       <= 1'b0;
      r_if_rsp     <= 1'b0;
      r_d_rsp      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_if_rdata   <= 32'd0;
      r_d_rdata    <= 32'd0;
    end else begin
      r_if_rsp <= 1'b0;
      r_d_rsp  <= 1'b0;

      if (w_d_acc) begin
        r_owner_d    <= 1'b1;
        r_we         <= d_we;
        r_addr       <= d_addr;
        r_wdata      <= d_we ? d_wdata : 32'd0;
        r_be         <= d_we ? d_be : 4'hF;
        r_last_grant <= C_DATA;
      end else if (w_if_acc) begin
        r_owner_d    <= 1'b0;
        r_we         <= 1'b0;
        r_addr       <= if_addr;
        r_wdata      <= 32'd0;
        r_be         <= 4'hF;
        r_last_grant <= C_FETCH;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= C_CNT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_done) begin
        if (r_owner_d) begin
          r_d_rsp   <= 1'b1;
          r_d_rdata <= r_we ? 32'd0 : mem_rdata;
        end else begin
          r_if_rsp   <= 1'b1;
          r_if_rdata <= mem_rdata;
        end
      end

      // A new fetch accepted in a response cycle starts with a fresh drop flag.
      if (w_if_acc) begin
        r_drop <= if_flush;
      end else if (w_fetch_busy && if_flush) begin
        r_drop <= 1'b1;
      end else if (r_if_rsp) begin
        r_drop <= 1'b0;
      end
    end
  end

  assign if_rsp_valid = r_if_rsp && !r_drop && !if_flush;
  assign if_rdata     = r_if_rdata;
  assign d_rsp_valid  = r_d_rsp;
  assign d_rdata      = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed stimulus with a cycle-accurate scoreboard |
// | for mem_port_arbiter. Revision: 1.0                                    |
// +------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_req_ready;
  logic        if_flush = 1'b0;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;
  logic        d_req_valid = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [3:0]  d_be = 4'd0;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;

  mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          drop;
  } rsp_t;

  mem_t mem_q[$];
  rsp_t dq[$];
  rsp_t iq[$];
  int   grant_log[$];

  int          ntot = 0;
  int          nbad = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          next_idle = 0;
  bit          m_last = 1'b0;
  logic [31:0] m_d_rdata = 32'd0;
  logic [31:0] m_if_rdata = 32'd0;
  bit          pend_v = 1'b0;
  int          pend_cyc = 0;
  logic [31:0] pend_data = 32'd0;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and scoreboard monitor.
  always @(negedge clk) begin
    bit   idle, exp_dr, exp_ir, exp_v;
    mem_t me;
    rsp_t re;
    if (chk_en) begin
      idle   = (cyc >= next_idle) && !reset;
      exp_dr = idle && !(if_req_valid && m_last);
      exp_ir = idle && !(d_req_valid && !m_last);
      chk("d_req_ready", {31'd0, d_req_ready}, {31'd0, exp_dr});
      chk("if_req_ready", {31'd0, if_req_ready}, {31'd0, exp_ir});

      if (if_flush) foreach (iq[i]) iq[i].drop = 1'b1;

      if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
        me = mem_q.pop_front();
        chk("mem_en", {31'd0, mem_en}, 32'd1);
        chk("mem_addr", mem_addr, me.addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, me.we});
        chk("mem_be", {28'd0, mem_be}, {28'd0, me.be});
        if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
        pend_v    = 1'b1;
        pend_cyc  = cyc + LAT;
        pend_data = mdat(me.addr);
      end else begin
        chk("mem_en_idle", {31'd0, mem_en}, 32'd0);
      end

      exp_v = dq.size() > 0 && dq[0].cyc == cyc;
      if (exp_v) begin
        re = dq.pop_front();
        m_d_rdata = re.data;
      end
      chk("d_rsp_valid", {31'd0, d_rsp_valid}, {31'd0, exp_v});
      chk("d_rdata", d_rdata, m_d_rdata);

      exp_v = 1'b0;
      if (iq.size() > 0 && iq[0].cyc == cyc) begin
        re = iq.pop_front();
        m_if_rdata = re.data;
        exp_v = !re.drop;
      end
      chk("if_rsp_valid", {31'd0, if_rsp_valid}, {31'd0, exp_v});
      chk("if_rdata", if_rdata, m_if_rdata);

      if (d_req_valid && exp_dr) begin
        mem_q.push_back('{cyc + 1, d_addr, d_we, d_wdata, d_we ? d_be : 4'hF});
        dq.push_back('{cyc + 2 + LAT, d_we ? 32'd0 : mdat(d_addr), 1'b0});
        grant_log.push_back(1);
        m_last    = 1'b1;
        next_idle = cyc + LAT + 2;
      end else if (if_req_valid && exp_ir) begin
        mem_q.push_back('{cyc + 1, if_addr, 1'b0, 32'd0, 4'hF});
        iq.push_back('{cyc + 2 + LAT, mdat(if_addr), if_flush});
        grant_log.push_back(0);
        m_last    = 1'b0;
        next_idle = cyc + LAT + 2;
      end
    end
    if (reset) begin
      mem_q.delete();
      dq.delete();
      iq.delete();
      m_last     = 1'b0;
      next_idle  = cyc + 1;
      m_d_rdata  = 32'd0;
      m_if_rdata = 32'd0;
    end
    mem_rdata = (pend_v && pend_cyc == cyc) ? pend_data : 32'hBAD0BAD0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    bit got = 1'b0;
    d_req_valid = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (d_req_ready) got = 1'b1;
      tick();
    end
    d_req_valid = 1'b0;
    if (!got) begin
      ntot++; nbad++;
      $display("FAIL d_accept_timeout: got no grant want grant (addr %h)", a);
    end
  endtask

  task automatic req_if(input logic [31:0] a);
    bit got = 1'b0;
    if_req_valid = 1'b1; if_addr = a;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_req_ready) got = 1'b1;
      tick();
    end
    if_req_valid = 1'b0;
    if (!got) begin
      ntot++; nbad++;
      $display("FAIL if_accept_timeout: got no grant want grant (addr %h)", a);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // Single load and a partial-byte store.
    req_d(1'b0, 32'h100, 32'h0, 4'h0);
    repeat (LAT + 2) tick();
    req_d(1'b1, 32'h20, 32'h12345678, 4'b0011);
    repeat (LAT + 2) tick();

    // Contention from reset: data, fetch, data, fetch.
    do_reset();
    grant_log.delete();
    fork
      begin req_d(1'b0, 32'h1000, 32'h0, 4'h0); req_d(1'b1, 32'h1004, 32'hCAFEF00D, 4'b1100); end
      begin req_if(32'h2000); req_if(32'h2004); end
    join
    repeat (LAT + 2) tick();
    chk("grant_count", grant_log.size(), 32'd4);
    if (grant_log.size() == 4) begin
      chk("grant0", grant_log[0], 32'd1);
      chk("grant1", grant_log[1], 32'd0);
      chk("grant2", grant_log[2], 32'd1);
      chk("grant3", grant_log[3], 32'd0);
    end

    // Flush during WAIT, in the response cycle, and in IDLE.
    req_if(32'h400);
    tick();
    if_flush = 1'b1; tick(); if_flush = 1'b0;
    repeat (2) tick();
    req_if(32'h404);
    repeat (LAT + 1) tick();
    if_flush = 1'b1; tick(); if_flush = 1'b0;
    tick();
    if_flush = 1'b1; tick(); if_flush = 1'b0;
    req_if(32'h408);
    repeat (LAT + 2) tick();

    // Reset in the middle of a load's WAIT phase.
    req_d(1'b0, 32'h300, 32'h0, 4'h0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ctl", {25'd0, if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid,
                    mem_en, mem_we, 1'b0} | {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr | mem_wdata, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    tick();
    reset = 1'b0;
    repeat (LAT + 2) tick();
    grant_log.delete();
    fork
      req_d(1'b0, 32'h310, 32'h0, 4'h0);
      req_if(32'h320);
    join
    repeat (LAT + 2) tick();
    chk("tie_after_reset", (grant_log.size() > 0) ? grant_log[0] : 32'd9, 32'd1);

    // Fetch withdrawn while blocked behind a data access.
    req_d(1'b0, 32'h500, 32'h0, 4'h0);
    if_req_valid = 1'b1; if_addr = 32'h999;
    repeat (2) tick();
    if_req_valid = 1'b0;
    repeat (LAT + 4) tick();

    chk("mem_q_empty", mem_q.size(), 32'd0);
    chk("dq_empty", dq.size(), 32'd0);
    chk("iq_empty", iq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
